aes_sbox_arbiter: RTL

// - Shares a pool of NSBOX aes_sbox instances between two requesters: the round datapath
//   (SubBytes, 16-byte state) and the key expansion (SubWord, 4-byte word).
// - Sequences each job over the pool in beats and returns registered results over valid/ready.
// - Arbitrates round-robin at job granularity.
// - Sits between aes_round/aes_key_expand and the S-box lanes; replaces 20 dedicated S-boxes.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_sbox_lane_bank.sv | 22 ++
 rtl/aes_sbox_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box job FSM encoding, requester ids and the
// forward S-box function (GF(2^8) inverse followed by the affine map).
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN_ST,
    RUN_KEY
  } fsm_e;

  localparam logic REQ_ST  = 1'b0;
  localparam logic REQ_KEY = 1'b1;

  localparam int AES_STATE_BYTES = 16;
  localparam int AES_WORD_BYTES  = 4;

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
  function automatic logic [7:0] sbox_fwd(logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 7; k >= 0; k--) begin
      r = gf_mul(r, r);
      if (k != 0) r = gf_mul(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES forward S-box lane.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = sbox_fwd(a_i);

endmodule

// File: rtl/aes_sbox_lane_bank.sv
// NSBOX S-box lanes; lane i sees byte beat*NSBOX+i of the job buffer.
module aes_sbox_lane_bank
  import aes_pkg::*;
#(
  parameter int NSBOX = 4
) (
  input  logic [AES_STATE_BYTES*8-1:0] buf_i,
  input  logic [3:0]                   beat_i,
  output logic [NSBOX*8-1:0]           lanes_o
);

  for (genvar i = 0; i < NSBOX; i++) begin : g_lane
    logic [3:0] idx;
    assign idx = 4'(int'(beat_i) * NSBOX + i);

    aes_sbox u_sbox (
      .a_i(buf_i[8*idx +: 8]),
      .y_o(lanes_o[8*i +: 8])
    );
  end

endmodule

// File: rtl/aes_sbox_arbiter.sv
// Shares NSBOX S-box lanes between SubBytes (16 B) and SubWord (4 B) jobs,
// round-robin per job, with registered valid/ready responses.
module aes_sbox_arbiter
  import aes_pkg::*;
#(
  parameter int NSBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  input  logic         st_rsp_ready,
  output logic [127:0] st_rsp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_data,
  output logic         key_rsp_valid,
  input  logic         key_rsp_ready,
  output logic [31:0]  key_rsp_data,
  output logic         busy
);

  localparam int ST_BEATS  = AES_STATE_BYTES / NSBOX;
  localparam int KEY_BEATS = (NSBOX >= AES_WORD_BYTES) ? 1
                           : AES_WORD_BYTES / NSBOX;
  localparam int KEY_LANES = (NSBOX < AES_WORD_BYTES) ? NSBOX
                           : AES_WORD_BYTES;
  localparam logic [3:0] ST_LAST  = 4'(ST_BEATS - 1);
  localparam logic [3:0] KEY_LAST = 4'(KEY_BEATS - 1);

  fsm_e         state_q, state_d;
  logic [3:0]   beat_q, beat_d;
  logic         last_q, last_d;
  logic [127:0] buf_q, buf_d;
  logic         st_vld_q, st_vld_d;
  logic [127:0] st_dat_q, st_dat_d;
  logic         key_vld_q, key_vld_d;
  logic [31:0]  key_dat_q, key_dat_d;

  logic [NSBOX*8-1:0] lanes;
  logic idle, st_elig, key_elig, st_acc, key_acc;

  function automatic logic [3:0] st_idx(logic [3:0] b, int i);
    return 4'(int'(b) * NSBOX + i);
  endfunction

  function automatic logic [1:0] key_idx(logic [3:0] b, int i);
    return 2'(int'(b) * NSBOX + i);
  endfunction

  aes_sbox_lane_bank #(.NSBOX(NSBOX)) u_bank (
    .buf_i  (buf_q),
    .beat_i (beat_q),
    .lanes_o(lanes)
  );

  assign idle     = (state_q == IDLE);
  assign st_elig  = st_req_valid && !st_vld_q;
  assign key_elig = key_req_valid && !key_vld_q;

  // Ready looks only at the other side's eligibility, never at own valid
  assign st_req_ready  = idle && !st_vld_q
                      && (!key_elig || last_q == REQ_KEY);
  assign key_req_ready = idle && !key_vld_q
                      && (!st_elig || last_q == REQ_ST);
  assign st_acc  = st_req_valid && st_req_ready;
  assign key_acc = key_req_valid && key_req_ready;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    last_d    = last_q;
    buf_d     = buf_q;
    st_vld_d  = st_vld_q;
    st_dat_d  = st_dat_q;
    key_vld_d = key_vld_q;
    key_dat_d = key_dat_q;

    if (st_vld_q && st_rsp_ready) st_vld_d = 1'b0;
    if (key_vld_q && key_rsp_ready) key_vld_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (st_acc) begin
          state_d = RUN_ST;
          buf_d   = st_req_data;
          beat_d  = 4'd0;
          last_d  = REQ_ST;
        end else if (key_acc) begin
          state_d = RUN_KEY;
          buf_d   = {96'b0, key_req_data};
          beat_d  = 4'd0;
          last_d  = REQ_KEY;
        end
      end
      RUN_ST: begin
        for (int i = 0; i < NSBOX; i++)
          st_dat_d[8*st_idx(beat_q, i) +: 8] = lanes[8*i +: 8];
        beat_d = beat_q + 4'd1;
        if (beat_q == ST_LAST) begin
          state_d  = IDLE;
          beat_d   = 4'd0;
          st_vld_d = 1'b1;
        end
      end
      RUN_KEY: begin
        for (int i = 0; i < KEY_LANES; i++)
          key_dat_d[8*key_idx(beat_q, i) +: 8] = lanes[8*i +: 8];
        beat_d = beat_q + 4'd1;
        if (beat_q == KEY_LAST) begin
          state_d   = IDLE;
          beat_d    = 4'd0;
          key_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= 4'd0;
      last_q    <= REQ_ST;
      buf_q     <= '0;
      st_vld_q  <= 1'b0;
      st_dat_q  <= '0;
      key_vld_q <= 1'b0;
      key_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      buf_q     <= buf_d;
      st_vld_q  <= st_vld_d;
      st_dat_q  <= st_dat_d;
      key_vld_q <= key_vld_d;
      key_dat_q <= key_dat_d;
    end
  end

  assign st_rsp_valid  = st_vld_q;
  assign st_rsp_data   = st_dat_q;
  assign key_rsp_valid = key_vld_q;
  assign key_rsp_data  = key_dat_q;
  assign busy          = (state_q != IDLE);

endmodule
